// File: rtl/forward_permute_map_if.sv
// ----------------------------------------------------------------------------
// forward_permute_map_if
// Handshake bundle for the forward permutation engine.
//   in_valid  : source word on data_in is valid        (master -> slave)
//   in_ready  : engine can accept a word                (slave  -> master)
//   data_in   : 64-bit source word, bit 0 is the MSB    (master -> slave)
//   out_valid : data_out holds a finished result        (slave  -> master)
//   out_ready : downstream accepts data_out             (master -> slave)
//   data_out  : 64-bit permuted word, bit 0 is the MSB  (slave  -> master)
//   status    : copy of out_valid for the status chain  (slave  -> master)
//   busy      : engine is scattering a word             (slave  -> master)
// ----------------------------------------------------------------------------
interface forward_permute_map_if;
   logic        in_valid;
   logic        in_ready;
   logic [0:63] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [0:63] data_out;
   logic        status;
   logic        busy;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out, status, busy
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out, status, busy
   );
endinterface

// File: rtl/forward_permute_map.sv
// ----------------------------------------------------------------------------
// forward_permute_map
// Multi-cycle forward bit-permutation engine: data_out[MAP[i]] = data_in[i].
// One word is accepted per handshake, LANES source bits are scattered per
// cycle, and the result is held until downstream takes it.
// Ports:
//   clk : rising-edge clock
//   set : synchronous active-high reset
//   bus : forward_permute_map_if.slave (in/out handshakes, data, status, busy)
// Parameter:
//   LANES : source bits scattered per cycle (1, 2, 4, 8, 16, 32 or 64)
// ----------------------------------------------------------------------------
module forward_permute_map #(
   parameter int LANES = 8
) (
   input  logic                        clk,
   input  logic                        set,
   forward_permute_map_if.slave        bus
);

   localparam int         NGRP     = 64 / LANES;
   localparam logic [6:0] LAST_GRP = 7'(NGRP - 1);

   // Forward permutation table: source bit i lands on output bit MAP[i].
   localparam logic [5:0] MAP [0:63] = '{
      6'd26, 6'd51, 6'd41, 6'd11, 6'd34, 6'd56, 6'd12, 6'd50,
      6'd61, 6'd25, 6'd55, 6'd44, 6'd35, 6'd49, 6'd21, 6'd58,
      6'd24, 6'd43, 6'd18, 6'd2,  6'd33, 6'd36, 6'd52, 6'd32,
      6'd63, 6'd1,  6'd53, 6'd42, 6'd57, 6'd3,  6'd31, 6'd22,
      6'd13, 6'd54, 6'd9,  6'd40, 6'd5,  6'd37, 6'd19, 6'd62,
      6'd39, 6'd8,  6'd29, 6'd0,  6'd27, 6'd20, 6'd59, 6'd48,
      6'd16, 6'd28, 6'd45, 6'd7,  6'd17, 6'd4,  6'd30, 6'd23,
      6'd47, 6'd14, 6'd6,  6'd38, 6'd10, 6'd15, 6'd46, 6'd60
   };

   // Source bit that feeds output bit dst (MAP is a bijection).
   function automatic int src_of(input int dst);
      int s;
      s = 0;
      for (int i = 0; i < 64; i++) begin
         if (int'(MAP[i]) == dst) begin
            s = i;
         end
      end
      return s;
   endfunction

   generate
      if (!((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8) ||
            (LANES == 16) || (LANES == 32) || (LANES == 64))) begin : g_bad_lanes
         $error("forward_permute_map: LANES must be 1, 2, 4, 8, 16, 32 or 64");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_grp;
   logic [0:63] r_src;
   logic [0:63] r_data_out;
   logic        r_in_ready;
   logic        r_out_valid;
   logic        r_status;
   logic        r_busy;
   logic        w_in_ready_nxt;
   logic        w_out_valid_nxt;
   logic        w_busy_nxt;
   logic [0:63] w_hit;
   logic [0:63] w_scatter;

   // Gather view of the scatter: each output bit j knows its (constant) source
   // bit and the lane group in which it is written, so a RUN cycle only needs
   // a per-bit compare against the group counter.
   generate
      for (genvar j = 0; j < 64; j++) begin : g_scatter
         localparam int SRC = src_of(j);
         assign w_hit[j]     = (r_grp == 7'(SRC / LANES));
         assign w_scatter[j] = r_src[SRC];
      end
   endgenerate

   // State register and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (set) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_status    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_status    <= w_out_valid_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (r_grp == LAST_GRP) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state, so the outputs leave a register.
   always_comb begin
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
      case (w_state_nxt)
         S_IDLE:  w_in_ready_nxt  = 1'b1;
         S_RUN:   w_busy_nxt      = 1'b1;
         S_DONE:  w_out_valid_nxt = 1'b1;
         default: w_in_ready_nxt  = 1'b1;
      endcase
   end

   // Datapath: latch source on accept, scatter one lane group per RUN cycle.
   always_ff @(posedge clk) begin
      if (set) begin
         r_grp      <= 7'd0;
         r_src      <= 64'd0;
         r_data_out <= 64'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_src      <= bus.data_in;
                  r_data_out <= 64'd0;
                  r_grp      <= 7'd0;
               end
            end
            S_RUN: begin
               r_data_out <= (r_data_out & ~w_hit) | (w_scatter & w_hit);
               r_grp      <= r_grp + 7'd1;
            end
            default: begin
               r_grp <= r_grp;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.status    = r_status;
   assign bus.busy      = r_busy;
   assign bus.data_out  = r_data_out;

endmodule
